// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   Registered control decoder sitting between fetch and execute. Decodes a
//   32-bit instruction into the datapath control bundle and holds it in one
//   pipeline register with valid/ready handshaking. MUL is held back for
//   MUL_CYCLES cycles before it is presented downstream. Unknown opcodes are
//   flagged (illegal) and remembered (illegal_seen) until reset.
//
// Parameters
//   PC_W        width of the PC tag travelling with the instruction
//   MUL_CYCLES  MUL issue latency in cycles, 1..16
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   flush              drop the held entry, accept nothing this cycle
//   in_valid/in_ready  upstream handshake; instr + in_pc are the payload
//   out_valid/out_ready downstream handshake; out_pc + control bits payload
//   MemToReg .. RegWrite, ALUControl  decoded control bundle
//   illegal            held opcode matched no decode entry
//   illegal_seen       sticky: an illegal instruction was accepted since rst
module decode_ctrl_pipe #(
   parameter int PC_W       = 32,
   parameter int MUL_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic            MemToReg,
   output logic            MemWrite,
   output logic            branch,
   output logic            beq,
   output logic            bne,
   output logic            bgt,
   output logic            blt,
   output logic            bge,
   output logic            ble,
   output logic            link,
   output logic            ret,
   output logic            StackSrc,
   output logic            ALUSrc,
   output logic            RegDst,
   output logic            RegWrite,
   output logic [2:0]      ALUControl,
   output logic            illegal,
   output logic            illegal_seen
);

   typedef enum logic [1:0] {EMPTY, MULW, FULL} state_t;

   typedef struct packed {
      logic       mem_to_reg;
      logic       mem_write;
      logic       branch;
      logic       beq;
      logic       bne;
      logic       bgt;
      logic       blt;
      logic       bge;
      logic       ble;
      logic       link;
      logic       ret;
      logic       stack_src;
      logic       alu_src;
      logic       reg_dst;
      logic       reg_write;
      logic [2:0] alu_control;
      logic       illegal;
   } ctrl_t;

   state_t      state;
   logic [3:0]  cnt;
   ctrl_t       ctrl_q;
   ctrl_t       dec;
   logic        is_mul;
   logic        accept;

   logic [11:0] opcode;
   logic [7:0]  sh;

   assign opcode = instr[31:20];
   assign sh     = instr[11:4];

   // Instruction bits that carry register numbers/immediates only.
   logic unused_bits;
   assign unused_bits = ^{instr[19:12], instr[3:0]};

   // ---------------------------------------------------------------------
   // Decode table. Exact 12-bit opcodes win; everything else falls through
   // to the branch family keyed on opcode[11:4].
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      dec    = '0;
      is_mul = 1'b0;
      case (opcode)
         12'he1a: begin
            dec.reg_write = 1'b1;
            if (sh != 8'd0) begin
               dec.alu_control = 3'b100;
               dec.alu_src     = 1'b1;
               dec.reg_dst     = (sh[3:0] != 4'd1);
            end
         end
         12'he3a: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; end
         12'he08, 12'he28: begin
            dec.alu_src     = 1'b1;
            dec.reg_dst     = opcode[5];
            dec.alu_control = 3'b010;
            dec.reg_write   = 1'b1;
         end
         12'he04, 12'he24: begin
            dec.alu_src     = 1'b1;
            dec.reg_dst     = opcode[5];
            dec.alu_control = 3'b110;
            dec.reg_write   = 1'b1;
         end
         12'he15, 12'he35: begin
            dec.alu_src     = 1'b1;
            dec.reg_dst     = opcode[5];
            dec.alu_control = 3'b110;
         end
         12'he00: begin
            dec.alu_control = 3'b101;
            dec.alu_src     = 1'b1;
            dec.reg_write   = 1'b1;
            is_mul          = 1'b1;
         end
         12'he20: begin
            dec.alu_src   = 1'b1;
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
         end
         12'he59, 12'he79: begin
            dec.mem_to_reg  = 1'b1;
            dec.alu_control = 3'b010;
            dec.alu_src     = 1'b1;
            dec.reg_write   = 1'b1;
            dec.reg_dst     = ~opcode[5];
         end
         12'he58: begin
            dec.mem_write   = 1'b1;
            dec.alu_control = 3'b010;
            dec.alu_src     = 1'b1;
            dec.reg_dst     = 1'b1;
         end
         12'he52: begin
            dec.mem_write   = 1'b1;
            dec.stack_src   = 1'b1;
            dec.alu_control = 3'b110;
            dec.alu_src     = 1'b1;
            dec.reg_dst     = 1'b1;
         end
         12'he49: begin
            dec.mem_to_reg  = 1'b1;
            dec.stack_src   = 1'b1;
            dec.alu_control = 3'b010;
            dec.alu_src     = 1'b1;
            dec.reg_dst     = 1'b1;
            dec.reg_write   = 1'b1;
         end
         default: begin
            dec.alu_src     = 1'b1;
            dec.alu_control = opcode[3] ? 3'b110 : 3'b010;
            case (opcode[11:4])
               8'hea: dec.branch = 1'b1;
               8'h0a: dec.beq    = 1'b1;
               8'h1a: dec.bne    = 1'b1;
               8'hca: dec.bgt    = 1'b1;
               8'hba: dec.blt    = 1'b1;
               8'haa: dec.bge    = 1'b1;
               8'hda: dec.ble    = 1'b1;
               8'heb: begin dec.branch = 1'b1; dec.link = 1'b1; end
               8'he1: begin dec.branch = 1'b1; dec.ret  = 1'b1; end
               default: begin
                  dec         = '0;
                  dec.illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Handshake and pipeline register
   // ---------------------------------------------------------------------
   assign in_ready  = !rst && !flush &&
                      (state == EMPTY || (state == FULL && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == FULL);

   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state        <= EMPTY;
         cnt          <= 4'd0;
         ctrl_q       <= '0;
         out_pc       <= '0;
         illegal_seen <= 1'b0;
      end else if (flush) begin
         // illegal_seen deliberately survives a flush.
         state  <= EMPTY;
         cnt    <= 4'd0;
         ctrl_q <= '0;
         out_pc <= '0;
      end else if (accept) begin
         // accept is only possible from EMPTY or from FULL being drained,
         // so loading here also covers the back-to-back case.
         ctrl_q <= dec;
         out_pc <= in_pc;
         if (dec.illegal) illegal_seen <= 1'b1;
         if (is_mul && MUL_CYCLES > 1) begin
            state <= MULW;
            cnt   <= 4'(MUL_CYCLES - 1);
         end else begin
            state <= FULL;
         end
      end else begin
         case (state)
            MULW: begin
               if (cnt == 4'd1) begin
                  state <= FULL;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            FULL:    if (out_ready) state <= EMPTY;
            default: ;
         endcase
      end
   end

   assign MemToReg   = ctrl_q.mem_to_reg;
   assign MemWrite   = ctrl_q.mem_write;
   assign branch     = ctrl_q.branch;
   assign beq        = ctrl_q.beq;
   assign bne        = ctrl_q.bne;
   assign bgt        = ctrl_q.bgt;
   assign blt        = ctrl_q.blt;
   assign bge        = ctrl_q.bge;
   assign ble        = ctrl_q.ble;
   assign link       = ctrl_q.link;
   assign ret        = ctrl_q.ret;
   assign StackSrc   = ctrl_q.stack_src;
   assign ALUSrc     = ctrl_q.alu_src;
   assign RegDst     = ctrl_q.reg_dst;
   assign RegWrite   = ctrl_q.reg_write;
   assign ALUControl = ctrl_q.alu_control;
   assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed self-checking bench for decode_ctrl_pipe (PC_W=32, MUL_CYCLES=3).
module tb_decode_ctrl_pipe;

   typedef struct packed {
      logic       mem_to_reg;
      logic       mem_write;
      logic       branch;
      logic       beq;
      logic       bne;
      logic       bgt;
      logic       blt;
      logic       bge;
      logic       ble;
      logic       link;
      logic       ret;
      logic       stack_src;
      logic       alu_src;
      logic       reg_dst;
      logic       reg_write;
      logic [2:0] alu_control;
      logic       illegal;
   } ctl_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] instr, in_pc, out_pc;
   logic        MemToReg, MemWrite, branch, beq, bne, bgt, blt, bge, ble;
   logic        link, ret, StackSrc, ALUSrc, RegDst, RegWrite;
   logic [2:0]  ALUControl;
   logic        illegal, illegal_seen;
   ctl_t        obs;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decode_ctrl_pipe #(.PC_W(32), .MUL_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .MemToReg(MemToReg), .MemWrite(MemWrite), .branch(branch),
      .beq(beq), .bne(bne), .bgt(bgt), .blt(blt), .bge(bge), .ble(ble),
      .link(link), .ret(ret), .StackSrc(StackSrc), .ALUSrc(ALUSrc),
      .RegDst(RegDst), .RegWrite(RegWrite), .ALUControl(ALUControl),
      .illegal(illegal), .illegal_seen(illegal_seen)
   );

   assign obs = {MemToReg, MemWrite, branch, beq, bne, bgt, blt, bge, ble,
                 link, ret, StackSrc, ALUSrc, RegDst, RegWrite, ALUControl,
                 illegal};

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic ctl_t ctl(input logic [2:0] alu, input logic src,
                                input logic rd, input logic rw);
      ctl_t c;
      c = '0;
      c.alu_control = alu;
      c.alu_src     = src;
      c.reg_dst     = rd;
      c.reg_write   = rw;
      return c;
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer an instruction that must be accepted on the coming edge.
   task automatic offer(input string tag, input logic [31:0] i,
                        input logic [31:0] pc);
      in_valid = 1'b1;
      instr    = i;
      in_pc    = pc;
      #1;
      check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      tick();
   endtask

   task automatic expect_out(input string tag, input logic v,
                             input logic [31:0] pc, input ctl_t e);
      check({tag, " out_valid"}, 64'(out_valid), 64'(v));
      check({tag, " out_pc"},    64'(out_pc),    64'(pc));
      check({tag, " ctl"},       64'(obs),       64'(e));
   endtask

   ctl_t e, held;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instr = '0; in_pc = '0;

      // ---------------- reset ----------------
      tick(); tick();
      expect_out("reset", 1'b0, 32'h0, '0);
      check("reset in_ready",     64'(in_ready),     64'd0);
      check("reset illegal_seen", 64'(illegal_seen), 64'd0);
      rst = 1'b0;
      #1;
      check("idle in_ready", 64'(in_ready), 64'd1);

      // ---------------- back-to-back ADD, MOV ----------------
      offer("add", 32'hE0810002, 32'h100);
      expect_out("add", 1'b1, 32'h100, ctl(3'b010, 1, 0, 1));
      offer("mov", 32'hE1A00001, 32'h104);
      expect_out("mov", 1'b1, 32'h104, ctl(3'b000, 0, 0, 1));
      in_valid = 1'b0;
      tick();
      check("drain out_valid", 64'(out_valid), 64'd0);

      // ---------------- LSL variants, streamed ----------------
      offer("lsl10", 32'hE1A00100, 32'h110);
      expect_out("lsl10", 1'b1, 32'h110, ctl(3'b100, 1, 1, 1));
      offer("lsl11", 32'hE1A00110, 32'h114);
      expect_out("lsl11", 1'b1, 32'h114, ctl(3'b100, 1, 0, 1));
      offer("lsl0", 32'hE1A00000, 32'h118);
      expect_out("lsl0", 1'b1, 32'h118, ctl(3'b000, 0, 0, 1));
      in_valid = 1'b0;
      tick();

      // ---------------- MUL then ADD ----------------
      offer("mul", 32'hE0000291, 32'h200);
      in_valid = 1'b1; instr = 32'hE0810002; in_pc = 32'h204;
      #1;
      check("mulw1 in_ready",  64'(in_ready),  64'd0);
      check("mulw1 out_valid", 64'(out_valid), 64'd0);
      tick();
      check("mulw2 in_ready",  64'(in_ready),  64'd0);
      check("mulw2 out_valid", 64'(out_valid), 64'd0);
      tick();
      expect_out("mul done", 1'b1, 32'h200, ctl(3'b101, 1, 0, 1));
      check("mul done in_ready", 64'(in_ready), 64'd1);
      tick();
      expect_out("add after mul", 1'b1, 32'h204, ctl(3'b010, 1, 0, 1));
      in_valid = 1'b0;
      tick();

      // ---------------- branches + back-pressure ----------------
      offer("b", 32'hEAFFFFFE, 32'h300);
      e = ctl(3'b110, 1, 0, 0); e.branch = 1'b1;
      expect_out("b", 1'b1, 32'h300, e);
      offer("beq", 32'h0A000004, 32'h304);
      e = ctl(3'b010, 1, 0, 0); e.beq = 1'b1;
      expect_out("beq", 1'b1, 32'h304, e);
      offer("bl", 32'hEB000010, 32'h308);
      held = ctl(3'b010, 1, 0, 0); held.branch = 1'b1; held.link = 1'b1;
      expect_out("bl", 1'b1, 32'h308, held);
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'hE0810002; in_pc = 32'h30C;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("stall in_ready", 64'(in_ready), 64'd0);
         tick();
         expect_out("stall", 1'b1, 32'h308, held);
      end
      out_ready = 1'b1;
      offer("post-stall add", 32'hE0810002, 32'h30C);
      expect_out("post-stall add", 1'b1, 32'h30C, ctl(3'b010, 1, 0, 1));

      // ---------------- flush during MULW ----------------
      offer("mul2", 32'hE0000291, 32'h400);
      flush = 1'b1; in_valid = 1'b1; instr = 32'hE0810002; in_pc = 32'h404;
      #1;
      check("flush mulw in_ready", 64'(in_ready), 64'd0);
      tick();
      expect_out("flush mulw", 1'b0, 32'h0, '0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      check("flush mulw gone1", 64'(out_valid), 64'd0);
      tick();
      check("flush mulw gone2", 64'(out_valid), 64'd0);

      // ---------------- flush while FULL with an offer ----------------
      offer("add5", 32'hE0810002, 32'h500);
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h504;
      #1;
      check("flush full in_ready", 64'(in_ready), 64'd0);
      tick();
      expect_out("flush full", 1'b0, 32'h0, '0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      check("flush full dropped", 64'(out_valid), 64'd0);

      // ---------------- reset mid-MULW ----------------
      offer("mul3", 32'hE0000291, 32'h600);
      rst = 1'b1; in_valid = 1'b0;
      #1;
      check("rst in_ready", 64'(in_ready), 64'd0);
      tick();
      expect_out("rst mulw", 1'b0, 32'h0, '0);
      rst = 1'b0;
      tick();
      check("rst mulw stays empty", 64'(out_valid), 64'd0);

      // ---------------- illegal ----------------
      offer("illegal", 32'hFFFFFFFF, 32'h700);
      e = '0; e.illegal = 1'b1;
      expect_out("illegal", 1'b1, 32'h700, e);
      check("illegal_seen set", 64'(illegal_seen), 64'd1);
      in_valid = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("illegal_seen after flush", 64'(illegal_seen), 64'd1);
      check("illegal after flush",      64'(illegal),      64'd0);
      offer("add7", 32'hE0810002, 32'h704);
      in_valid = 1'b0;
      check("illegal_seen after add", 64'(illegal_seen), 64'd1);
      check("illegal on add",         64'(illegal),      64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("illegal_seen after rst", 64'(illegal_seen), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
